gelato_inst_buffer: RTL
=======================

GELATO_INST_BUFFER -- requirements
Module: gelato_inst_buffer

Interface
REQ-001 SHALL have parameter NUM_WARPS, default 4, number of warps buffered (power of two, at least 2).
REQ-002 SHALL have parameter DEPTH, default 2, entries per warp FIFO (power of two, at least 2).
REQ-003 SHALL have parameter PC_W, default 32, width of PC and instruction word.
REQ-004 SHALL have parameter ST_W, default 2, width of split-table index.
REQ-005 SHALL have ports, in order:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- rdy  in  1  global enable; low freezes all state.
- in_valid  in  1  raw instruction present from fetch stage.
- in_pc  in  PC_W  PC of raw instruction.
- in_inst  in  PC_W  raw instruction word.
- in_warp  in  log2(NUM_WARPS)  owning warp.
- in_split  in  ST_W  split-table index.
- full  out  NUM_WARPS  per-warp FIFO full; fetch scheduler does not issue a warp whose bit is set.
- flush_valid  in  1  discard one warp's buffered instructions (redirect).
- flush_warp  in  log2(NUM_WARPS)  warp to flush.
- out_valid  out  1  instruction offered to decode.
- out_ready  in  1  decode accepts.
- out_pc, out_inst  out  PC_W  head entry of selected warp.
- out_warp  out  log2(NUM_WARPS)  selected warp.
- out_split  out  ST_W  split index of head entry.
- overflow  out  1  sticky error: push attempted into a full FIFO.

Function
REQ-006 SHALL hold one independent FIFO per warp with DEPTH entries {pc, inst, split}, read/write pointers and an occupancy count of width log2(DEPTH)+1.
REQ-007 Push: when rdy and in_valid, SHALL write to FIFO[in_warp] at the clock edge; the entry is visible at the output the next cycle at the earliest (1-cycle latency).
REQ-008 full[w] SHALL equal (count[w] == DEPTH), driven combinationally from registered count.
REQ-009 Push into a full FIFO SHALL be dropped and SHALL set overflow, which stays 1 until reset.
REQ-010 Selection SHALL be round-robin: starting at pointer rr, pick the first warp w (rr, rr+1, ... modulo NUM_WARPS) with count[w] != 0 and not (flush_valid and flush_warp == w).
REQ-011 out_valid SHALL be 1 iff a warp is selected; out_* SHALL present the head of that FIFO combinationally; out_* SHALL be don't-care when out_valid is 0.
REQ-012 Pop: when rdy, out_valid and out_ready, SHALL advance the selected FIFO read pointer and set rr to selected+1 (wrapping); rr SHALL be unchanged otherwise.
REQ-013 Push and pop on the same warp in the same cycle SHALL both take effect; count unchanged; a full FIFO SHALL accept that push (full evaluated after the pop).
REQ-014 Flush: when rdy and flush_valid, FIFO[flush_warp] SHALL be emptied (pointers and count to 0) at the edge; a push to the same warp in that cycle SHALL be discarded without setting overflow.
REQ-015 Pointers SHALL wrap from DEPTH-1 to 0.
REQ-016 When rdy is 0, no push, pop, flush or rr update SHALL occur; outputs SHALL still reflect current state.

Reset
REQ-017 On rst_n low, asynchronously: all counts, pointers and rr SHALL be 0; overflow 0; hence out_valid 0 and full all 0. Entry storage SHALL need no reset.
REQ-018 Reset asserted mid-operation SHALL discard all buffered entries; no entry SHALL be emitted after release until newly pushed.

Verification
REQ-019 Push warp 1 {pc=0x100, inst=0xDEADBEEF, split=2} with out_ready=0 -> next cycle out_valid=1, out_warp=1, out_pc=0x100, out_inst=0xDEADBEEF, out_split=2; stays until out_ready=1, then out_valid=0.
REQ-020 Push warp 0 twice with DEPTH=2 -> full[0]=1; third push to warp 0 -> dropped, overflow=1; pops yield the first two PCs in order.
REQ-021 One entry each in warps 0, 2, 3, out_ready=1 held -> output order warp 0, 2, 3; refill warp 0 after -> served after 3 (rr wraps).
REQ-022 Warp 2 full, same cycle pop of warp 2 and push to warp 2 -> push accepted, count stays 2, overflow stays 0.
REQ-023 Warp 1 holds 2 entries; flush_valid=1, flush_warp=1 together with a push to warp 1 -> out_valid=0 that cycle for warp 1, next cycle count[1]=0, full[1]=0, overflow=0.
REQ-024 rdy=0 with in_valid=1 and out_ready=1 -> no count change; assert rst_n=0 with entries held -> out_valid=0 immediately.

Source files
------------

// File: rtl/gelato_inst_buffer.sv
// Per-warp instruction buffer between fetch and decode.
// Each warp owns a small FIFO of {pc, inst, split} entries. Decode is fed from
// one warp at a time, chosen round-robin among non-empty warps that are not
// being flushed this cycle. A push into a full FIFO is dropped and latches a
// sticky overflow flag.
module gelato_inst_buffer #(
  parameter int NUM_WARPS = 4,
  parameter int DEPTH     = 2,
  parameter int PC_W      = 32,
  parameter int ST_W      = 2,
  localparam int WW       = $clog2(NUM_WARPS),
  localparam int AW       = $clog2(DEPTH),
  localparam int CW       = AW + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rdy,
  input  logic                 in_valid,
  input  logic [PC_W-1:0]      in_pc,
  input  logic [PC_W-1:0]      in_inst,
  input  logic [WW-1:0]        in_warp,
  input  logic [ST_W-1:0]      in_split,
  output logic [NUM_WARPS-1:0] full,
  input  logic                 flush_valid,
  input  logic [WW-1:0]        flush_warp,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PC_W-1:0]      out_pc,
  output logic [PC_W-1:0]      out_inst,
  output logic [WW-1:0]        out_warp,
  output logic [ST_W-1:0]      out_split,
  output logic                 overflow
);

  // Entry storage carries no reset: validity is tracked solely by count_r.
  logic [PC_W-1:0] mem_pc_r    [NUM_WARPS][DEPTH];
  logic [PC_W-1:0] mem_inst_r  [NUM_WARPS][DEPTH];
  logic [ST_W-1:0] mem_split_r [NUM_WARPS][DEPTH];

  logic [AW-1:0]   rd_ptr_r [NUM_WARPS];
  logic [AW-1:0]   wr_ptr_r [NUM_WARPS];
  logic [CW-1:0]   count_r  [NUM_WARPS];
  logic [WW-1:0]   rr_r;
  logic            overflow_r;

  logic            sel_found_s;
  logic [WW-1:0]   sel_warp_s;
  logic [WW-1:0]   cand_s;
  logic            pop_s;
  logic            push_req_s;
  logic            push_flushed_s;
  logic            room_s;
  logic            push_ok_s;
  logic            push_drop_s;
  logic [NUM_WARPS-1:0] wr_en_s;
  logic [NUM_WARPS-1:0] rd_en_s;
  logic [NUM_WARPS-1:0] flush_en_s;

  // Per-warp full flags and write/read/flush enables.
  for (genvar g = 0; g < NUM_WARPS; g++) begin : g_warp
    assign full[g]       = (count_r[g] == CW'(DEPTH));
    assign flush_en_s[g] = rdy & flush_valid & (flush_warp == WW'(g));
    assign wr_en_s[g]    = push_ok_s & (in_warp == WW'(g));
    assign rd_en_s[g]    = pop_s & (sel_warp_s == WW'(g));
  end

  // Round-robin pick: first non-empty, non-flushing warp starting at rr_r.
  always_comb begin
    sel_found_s = 1'b0;
    sel_warp_s  = {WW{1'b0}};
    cand_s      = {WW{1'b0}};
    for (int i = 0; i < NUM_WARPS; i++) begin
      cand_s = rr_r + WW'(i);
      if (!sel_found_s && (count_r[cand_s] != {CW{1'b0}}) &&
          !(flush_valid && (flush_warp == cand_s))) begin
        sel_found_s = 1'b1;
        sel_warp_s  = cand_s;
      end else begin
        sel_found_s = sel_found_s;
      end
    end
  end

  // A push into a full FIFO is still accepted when the same warp pops this cycle;
  // a push racing a flush of its own warp is silently discarded.
  assign pop_s          = rdy & sel_found_s & out_ready;
  assign push_req_s     = rdy & in_valid;
  assign push_flushed_s = push_req_s & flush_valid & (flush_warp == in_warp);
  assign room_s         = (count_r[in_warp] != CW'(DEPTH)) |
                          (pop_s & (sel_warp_s == in_warp));
  assign push_ok_s      = push_req_s & ~push_flushed_s & room_s;
  assign push_drop_s    = push_req_s & ~push_flushed_s & ~room_s;

  assign out_valid = sel_found_s;
  assign out_warp  = sel_warp_s;
  assign out_pc    = mem_pc_r[sel_warp_s][rd_ptr_r[sel_warp_s]];
  assign out_inst  = mem_inst_r[sel_warp_s][rd_ptr_r[sel_warp_s]];
  assign out_split = mem_split_r[sel_warp_s][rd_ptr_r[sel_warp_s]];
  assign overflow  = overflow_r;

  // Pointer, occupancy, round-robin and overflow state; frozen while rdy is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        rd_ptr_r[w] <= {AW{1'b0}};
        wr_ptr_r[w] <= {AW{1'b0}};
        count_r[w]  <= {CW{1'b0}};
      end
      rr_r       <= {WW{1'b0}};
      overflow_r <= 1'b0;
    end else if (rdy) begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        if (flush_en_s[w]) begin
          rd_ptr_r[w] <= {AW{1'b0}};
          wr_ptr_r[w] <= {AW{1'b0}};
          count_r[w]  <= {CW{1'b0}};
        end else begin
          if (wr_en_s[w]) wr_ptr_r[w] <= wr_ptr_r[w] + AW'(1);
          if (rd_en_s[w]) rd_ptr_r[w] <= rd_ptr_r[w] + AW'(1);
          if (wr_en_s[w] && !rd_en_s[w]) begin
            count_r[w] <= count_r[w] + CW'(1);
          end else if (rd_en_s[w] && !wr_en_s[w]) begin
            count_r[w] <= count_r[w] - CW'(1);
          end
        end
      end
      if (pop_s) rr_r <= sel_warp_s + WW'(1);
      if (push_drop_s) overflow_r <= 1'b1;
    end
  end

  // Entry write port: store the accepted push at the warp's write pointer.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_pc_r[in_warp][wr_ptr_r[in_warp]]    <= in_pc;
      mem_inst_r[in_warp][wr_ptr_r[in_warp]]  <= in_inst;
      mem_split_r[in_warp][wr_ptr_r[in_warp]] <= in_split;
    end
  end

endmodule
